// File: rtl/buffer_circular_pkg.sv
// Shared constants and width helpers for the circular buffer.
package buffer_circular_pkg;

   localparam int unsigned WIDTH_DEF = 64;
   localparam int unsigned NUM_DEF   = 8;

   // Bits needed to hold an occupancy count in 0..num.
   function automatic int unsigned count_width(input int unsigned num);
      return $clog2(num + 1);
   endfunction

   // Bits needed to address num entries (at least one bit).
   function automatic int unsigned ptr_width(input int unsigned num);
      return (num < 2) ? 1 : $clog2(num);
   endfunction

endpackage

// File: rtl/buffer_circular_mem.sv
// Entry storage: NUM x WIDTH, one synchronous write port and one
// asynchronous read port. Contents are deliberately not reset.
module buffer_circular_mem #(
   parameter int unsigned WIDTH = 64,
   parameter int unsigned NUM   = 8,
   parameter int unsigned AW    = 3
) (
   input  logic             clk_i,
   input  logic             we_i,
   input  logic [AW-1:0]    waddr_i,
   input  logic [WIDTH-1:0] wdata_i,
   input  logic [AW-1:0]    raddr_i,
   output logic [WIDTH-1:0] rdata_o
);

   logic [WIDTH-1:0] mem_q [NUM];

   // Write port: one word per enabled edge.
   always_ff @(posedge clk_i) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/buffer_circular_param.sv
// Parameterised circular FIFO with occupancy, almost-full and sticky
// overflow/underflow flags, plus a flush input.
//
// Build option: define BUFFER_CIRCULAR_FWFT_EN for first-word-fall-through
// reads; otherwise reads are registered (one-cycle valido_o pulse).
//
// Handshake: a push is taken on an edge where insercion_i is high and the
// buffer is not full (or a pop is taken on the same edge); a pop is taken
// where delecion_i is high and the buffer is not empty. There is no
// back-pressure signal: refused requests only raise the sticky error flags.
// valido_o qualifies dato_o; in registered mode it is a single-cycle pulse
// following each accepted pop, in FWFT mode it means "head word shown".
module buffer_circular_param
   import buffer_circular_pkg::*;
#(
   parameter int unsigned WIDTH        = WIDTH_DEF,
   parameter int unsigned NUM          = NUM_DEF,
   parameter int unsigned UMBRAL_LLENA = NUM - 2
) (
   input  logic                          clk_i,
   input  logic                          rstn_i,
   input  logic                          insercion_i,
   input  logic [WIDTH-1:0]              dato_i,
   input  logic                          delecion_i,
   input  logic                          vaciar_i,
   input  logic                          limpiar_err_i,
   output logic [WIDTH-1:0]              dato_o,
   output logic                          valido_o,
   output logic                          vacia_o,
   output logic                          llena_o,
   output logic                          casi_llena_o,
   output logic [count_width(NUM)-1:0]   ocupacion_o,
   output logic                          desborde_o,
   output logic                          subdesborde_o
);

   localparam int unsigned CW = count_width(NUM);
   localparam int unsigned PW = ptr_width(NUM);

   logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             vacia_q, llena_q, casi_q;
   logic             desb_q, subd_q;
   logic             pop_acc, push_acc;
   logic             ovf_evt, udf_evt;
   logic             wr_en;
   logic [WIDTH-1:0] rd_data;

   // Pointer increment with wrap at NUM-1 (NUM need not be a power of two).
   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(NUM - 1)) ? '0 : p + PW'(1);
   endfunction

   // Accept/refuse decisions and error events for this cycle.
   always_comb begin
      pop_acc  = delecion_i && !vacia_q;
      push_acc = insercion_i && (!llena_q || pop_acc);
      // A flush discards the cycle's requests, so they cannot be errors.
      ovf_evt  = insercion_i && !push_acc && !vaciar_i;
      udf_evt  = delecion_i && vacia_q && !vaciar_i;
      wr_en    = push_acc && !vaciar_i;
   end

   // Next occupancy: flush wins, simultaneous push+pop leaves it unchanged.
   always_comb begin
      cnt_d = cnt_q;
      if (vaciar_i) begin
         cnt_d = '0;
      end else if (push_acc && !pop_acc) begin
         cnt_d = cnt_q + CW'(1);
      end else if (pop_acc && !push_acc) begin
         cnt_d = cnt_q - CW'(1);
      end
   end

   // Pointers, occupancy and the registered status flags derived from it.
   always_ff @(posedge clk_i) begin
      if (!rstn_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
         vacia_q  <= 1'b1;
         llena_q  <= 1'b0;
         casi_q   <= 1'b0;
      end else begin
         if (vaciar_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
         end else begin
            if (push_acc) wr_ptr_q <= ptr_inc(wr_ptr_q);
            if (pop_acc)  rd_ptr_q <= ptr_inc(rd_ptr_q);
         end
         cnt_q   <= cnt_d;
         vacia_q <= (cnt_d == '0);
         llena_q <= (cnt_d == CW'(NUM));
         casi_q  <= (cnt_d >= CW'(UMBRAL_LLENA));
      end
   end

   // Sticky error flags: a new error in the clearing cycle still sets.
   always_ff @(posedge clk_i) begin
      if (!rstn_i) begin
         desb_q <= 1'b0;
         subd_q <= 1'b0;
      end else begin
         if (ovf_evt)            desb_q <= 1'b1;
         else if (limpiar_err_i) desb_q <= 1'b0;
         if (udf_evt)            subd_q <= 1'b1;
         else if (limpiar_err_i) subd_q <= 1'b0;
      end
   end

   buffer_circular_mem #(
      .WIDTH (WIDTH),
      .NUM   (NUM),
      .AW    (PW)
   ) u_mem (
      .clk_i   (clk_i),
      .we_i    (wr_en),
      .waddr_i (wr_ptr_q),
      .wdata_i (dato_i),
      .raddr_i (rd_ptr_q),
      .rdata_o (rd_data)
   );

`ifdef BUFFER_CIRCULAR_FWFT_EN
   // Head word shown directly; masked to zero while empty so stale or
   // never-written storage is not visible.
   assign dato_o   = vacia_q ? '0 : rd_data;
   assign valido_o = !vacia_q;
`else
   logic [WIDTH-1:0] dato_q;
   logic             valido_q;

   // Registered read: capture the head on an accepted pop, hold otherwise.
   always_ff @(posedge clk_i) begin
      if (!rstn_i) begin
         dato_q   <= '0;
         valido_q <= 1'b0;
      end else if (pop_acc && !vaciar_i) begin
         dato_q   <= rd_data;
         valido_q <= 1'b1;
      end else begin
         valido_q <= 1'b0;
      end
   end

   assign dato_o   = dato_q;
   assign valido_o = valido_q;
`endif

   assign vacia_o       = vacia_q;
   assign llena_o       = llena_q;
   assign casi_llena_o  = casi_q;
   assign ocupacion_o   = cnt_q;
   assign desborde_o    = desb_q;
   assign subdesborde_o = subd_q;

endmodule

// File: tb/tb_buffer_circular_param.sv
// Bench for buffer_circular_param (NUM=8, WIDTH=64, UMBRAL_LLENA=6).
// Honours BUFFER_CIRCULAR_FWFT_EN the same way as the design.
module tb_buffer_circular_param;

   localparam int unsigned W   = 64;
   localparam int unsigned N   = 8;
   localparam int unsigned THR = 6;

   logic          clk = 1'b0;
   logic          rstn_i;
   logic          insercion_i;
   logic [W-1:0]  dato_i;
   logic          delecion_i;
   logic          vaciar_i;
   logic          limpiar_err_i;
   logic [W-1:0]  dato_o;
   logic          valido_o;
   logic          vacia_o;
   logic          llena_o;
   logic          casi_llena_o;
   logic [3:0]    ocupacion_o;
   logic          desborde_o;
   logic          subdesborde_o;

   int checks = 0;
   int errors = 0;

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   buffer_circular_param #(
      .WIDTH        (W),
      .NUM          (N),
      .UMBRAL_LLENA (THR)
   ) dut (
      .clk_i         (clk),
      .rstn_i        (rstn_i),
      .insercion_i   (insercion_i),
      .dato_i        (dato_i),
      .delecion_i    (delecion_i),
      .vaciar_i      (vaciar_i),
      .limpiar_err_i (limpiar_err_i),
      .dato_o        (dato_o),
      .valido_o      (valido_o),
      .vacia_o       (vacia_o),
      .llena_o       (llena_o),
      .casi_llena_o  (casi_llena_o),
      .ocupacion_o   (ocupacion_o),
      .desborde_o    (desborde_o),
      .subdesborde_o (subdesborde_o)
   );

   task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   logic [W-1:0] mq[$];
   logic         m_desb = 1'b0;
   logic         m_subd = 1'b0;
   logic [W-1:0] m_dato = '0;
   logic         m_valido = 1'b0;
   bit           model_live = 1'b0;

   always @(posedge clk) begin
      bit pop, push, ovf, udf;
      if (!rstn_i) begin
         mq.delete();
         m_desb = 0; m_subd = 0; m_dato = '0; m_valido = 0;
         model_live = 1'b1;
      end else if (vaciar_i) begin
         mq.delete();
         m_valido = 0;
         if (limpiar_err_i) begin m_desb = 0; m_subd = 0; end
      end else begin
         pop  = delecion_i && (mq.size() > 0);
         push = insercion_i && ((mq.size() < N) || pop);
         ovf  = insercion_i && !push;
         udf  = delecion_i && (mq.size() == 0);
         if (pop) begin
            m_dato   = mq.pop_front();
            m_valido = 1;
         end else begin
            m_valido = 0;
         end
         if (push) mq.push_back(dato_i);
         if (ovf) m_desb = 1; else if (limpiar_err_i) m_desb = 0;
         if (udf) m_subd = 1; else if (limpiar_err_i) m_subd = 0;
      end
   end

   // ---------------- per-cycle compare ----------------
   always @(negedge clk) begin
      if (model_live) begin
         chk("vacia", W'(vacia_o), W'(mq.size() == 0));
         chk("llena", W'(llena_o), W'(mq.size() == N));
         chk("casi_llena", W'(casi_llena_o), W'(mq.size() >= THR));
         chk("ocupacion", W'(ocupacion_o), W'(mq.size()));
         chk("desborde", W'(desborde_o), W'(m_desb));
         chk("subdesborde", W'(subdesborde_o), W'(m_subd));
`ifdef BUFFER_CIRCULAR_FWFT_EN
         chk("valido", W'(valido_o), W'(mq.size() > 0));
         chk("dato", dato_o, (mq.size() > 0) ? mq[0] : '0);
`else
         chk("valido", W'(valido_o), W'(m_valido));
         chk("dato", dato_o, m_dato);
`endif
      end
   end

   // ---------------- driver tasks ----------------
   task automatic step(input logic ins, input logic [W-1:0] d, input logic del,
                       input logic vac, input logic clr);
      insercion_i   = ins;
      dato_i        = d;
      delecion_i    = del;
      vaciar_i      = vac;
      limpiar_err_i = clr;
      @(posedge clk);
      #1;
      insercion_i   = 1'b0;
      delecion_i    = 1'b0;
      vaciar_i      = 1'b0;
      limpiar_err_i = 1'b0;
   endtask

   task automatic push(input logic [W-1:0] d);
      step(1'b1, d, 1'b0, 1'b0, 1'b0);
   endtask

   // Pop (optionally with a push) and check the literal word returned.
   task automatic pop_chk(input logic ins, input logic [W-1:0] d, input logic [W-1:0] exp);
`ifdef BUFFER_CIRCULAR_FWFT_EN
      chk("pop_valido", W'(valido_o), W'(1));
      chk("pop_dato", dato_o, exp);
      step(ins, d, 1'b1, 1'b0, 1'b0);
`else
      step(ins, d, 1'b1, 1'b0, 1'b0);
      chk("pop_valido", W'(valido_o), W'(1));
      chk("pop_dato", dato_o, exp);
`endif
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      rstn_i = 1'b0; insercion_i = 0; dato_i = '0; delecion_i = 0;
      vaciar_i = 0; limpiar_err_i = 0;
      repeat (2) @(posedge clk);
      #1 rstn_i = 1'b1;
      step(0, '0, 0, 0, 0);
      chk("rst_vacia", W'(vacia_o), W'(1));
      chk("rst_ocup", W'(ocupacion_o), W'(0));
      chk("rst_valido", W'(valido_o), W'(0));
      chk("rst_dato", dato_o, W'(0));
      chk("rst_flags", W'({llena_o, casi_llena_o, desborde_o, subdesborde_o}), W'(0));

      // Fill 1..8, then overflow with 9.
      for (int i = 1; i <= 8; i++) begin
         push(W'(i));
         if (i == 5) chk("casi_after5", W'(casi_llena_o), W'(0));
         if (i == 6) chk("casi_after6", W'(casi_llena_o), W'(1));
      end
      chk("full_llena", W'(llena_o), W'(1));
      chk("full_ocup", W'(ocupacion_o), W'(8));
      push(W'(9));
      chk("ovf_desborde", W'(desborde_o), W'(1));
      chk("ovf_ocup", W'(ocupacion_o), W'(8));

      // Drain 1..8, underflow, clear both flags.
      for (int i = 1; i <= 8; i++) pop_chk(0, '0, W'(i));
      chk("drain_vacia", W'(vacia_o), W'(1));
      step(0, '0, 1, 0, 0);
      chk("udf_subdesborde", W'(subdesborde_o), W'(1));
      step(0, '0, 0, 0, 1);
      chk("clr_flags", W'({desborde_o, subdesborde_o}), W'(0));

      // Full buffer, 12 simultaneous push+pop: wrap the pointers.
      for (int i = 1; i <= 8; i++) push(W'(i));
      for (int i = 0; i < 12; i++) begin
         pop_chk(1, W'(100 + i), (i < 8) ? W'(i + 1) : W'(100 + i - 8));
         chk("wrap_ocup", W'(ocupacion_o), W'(8));
      end
      chk("wrap_desborde", W'(desborde_o), W'(0));

      // Flush with simultaneous push+pop.
      step(0, '0, 0, 1, 0);
      for (int i = 0; i < 3; i++) push(W'(200 + i));
      step(1, W'(77), 1, 1, 0);
      chk("flush_ocup", W'(ocupacion_o), W'(0));
      chk("flush_vacia", W'(vacia_o), W'(1));
      chk("flush_flags", W'({desborde_o, subdesborde_o}), W'(0));
      push(W'(42));
      pop_chk(0, '0, W'(42));

      // Error set wins over clear; push on empty with pop is accepted.
      step(1, W'(55), 1, 0, 1);
      chk("setwins_subd", W'(subdesborde_o), W'(1));
      chk("push_on_empty_ocup", W'(ocupacion_o), W'(1));
      pop_chk(0, '0, W'(55));

      // Random-value round trip through a partial fill.
      begin
         logic [W-1:0] vals [5];
         for (int i = 0; i < 5; i++) begin
            vals[i] = {$urandom, $urandom};
            push(vals[i]);
         end
         for (int i = 0; i < 5; i++) pop_chk(0, '0, vals[i]);
      end

      // Mid-operation reset discards contents.
      push(W'(11)); push(W'(12));
      rstn_i = 1'b0;
      step(0, '0, 0, 0, 0);
      rstn_i = 1'b1;
      chk("midrst_vacia", W'(vacia_o), W'(1));
      chk("midrst_ocup", W'(ocupacion_o), W'(0));
      step(0, '0, 0, 0, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
